// File: rtl/scroll_controller.sv
// ============================================================================
// Module      : scroll_controller
// Description : Turns per-frame ticks plus accel/brake/collision inputs into
//               road scroll-step pulses, speed, and the player alive/crash state.
//               Optional distance counter enabled by defining DISTANCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scroll_controller #(
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 8,
    parameter int CRASH_FRAMES = 120,
    parameter int SPEED_W      = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic               btn_accel_i,
    input  logic               btn_brake_i,
    input  logic               collision_i,
    output logic               update_signal_o,
    output logic               alive_o,
    output logic [SPEED_W-1:0] speed_o,
    output logic [1:0]         state_o
`ifdef DISTANCE_EN
    ,
    output logic [15:0]        distance_o
`endif
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_CRASH = 2'b10;

    localparam int c_AW = $clog2(ACCEL_FRAMES + 1);
    localparam int c_CW = $clog2(CRASH_FRAMES + 1);

    localparam logic [SPEED_W-1:0] c_MAX_S     = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W:0]   c_MAX_EXT   = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [c_AW-1:0]    c_ACCEL_LST = c_AW'(ACCEL_FRAMES - 1);
    localparam logic [c_CW-1:0]    c_CRASH_LST = c_CW'(CRASH_FRAMES - 1);

    logic [1:0]         state_q,  state_d;
    logic [SPEED_W-1:0] speed_q,  speed_d;
    logic [SPEED_W-1:0] acc_q,    acc_d;
    logic [c_AW-1:0]    acnt_q,   acnt_d;
    logic [c_CW-1:0]    ccnt_q,   ccnt_d;
    logic               upd_q,    upd_d;
    logic               alive_q,  alive_d;
    logic [SPEED_W:0]   w_sum;

    // Extra bit keeps the overflow visible before the modulus is subtracted.
    assign w_sum = {1'b0, acc_q} + {1'b0, speed_q};

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        acc_d   = acc_q;
        acnt_d  = acnt_q;
        ccnt_d  = ccnt_q;
        upd_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                speed_d = '0;
                if (start_i) begin
                    state_d = c_RUN;
                    acc_d   = '0;
                    acnt_d  = '0;
                end
            end
            c_RUN: begin
                if (collision_i) begin
                    state_d = c_CRASH;
                    speed_d = '0;
                    acc_d   = '0;
                    ccnt_d  = '0;
                end else if (frame_tick_i) begin
                    if (w_sum >= c_MAX_EXT) begin
                        upd_d = 1'b1;
                        acc_d = w_sum[SPEED_W-1:0] - c_MAX_S;
                    end else begin
                        acc_d = w_sum[SPEED_W-1:0];
                    end
                    if (acnt_q == c_ACCEL_LST) begin
                        acnt_d = '0;
                        if (btn_brake_i) begin
                            if (speed_q != '0) speed_d = speed_q - 1'b1;
                        end else if (btn_accel_i) begin
                            if (speed_q != c_MAX_S) speed_d = speed_q + 1'b1;
                        end
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            c_CRASH: begin
                speed_d = '0;
                if (frame_tick_i) begin
                    if (ccnt_q == c_CRASH_LST) begin
                        state_d = c_RUN;
                        ccnt_d  = '0;
                        acnt_d  = '0;
                        acc_d   = '0;
                    end else begin
                        ccnt_d = ccnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                speed_d = '0;
            end
        endcase
        alive_d = (state_d != c_CRASH);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= c_IDLE;
            speed_q <= '0;
            acc_q   <= '0;
            acnt_q  <= '0;
            ccnt_q  <= '0;
            upd_q   <= 1'b0;
            alive_q <= 1'b1;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            acc_q   <= acc_d;
            acnt_q  <= acnt_d;
            ccnt_q  <= ccnt_d;
            upd_q   <= upd_d;
            alive_q <= alive_d;
        end
    end

    assign update_signal_o = upd_q;
    assign alive_o         = alive_q;
    assign speed_o         = speed_q;
    assign state_o         = state_q;

`ifdef DISTANCE_EN
    logic [15:0] dist_q, dist_d;

    always_comb begin
        dist_d = dist_q;
        if (state_q == c_IDLE && start_i) begin
            dist_d = '0;
        end else if (upd_d) begin
            dist_d = dist_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dist_q <= '0;
        end else begin
            dist_q <= dist_d;
        end
    end

    assign distance_o = dist_q;
`endif

endmodule

`default_nettype wire
